tone_decoder: RTL and testbench
===============================

# tone_decoder

Receive-side counterpart of the music processor's speaker output. Accepts a 1-bit square-wave tone on an input pad, measures its rising-edge rate over a fixed 100 ms gate derived from `ticks_per_milli`, and classifies it as one of eight notes, C4 through C5. The note is shown as a letter on the 7-segment LED bus. It sits beside `music_processor` in the top level: `uio_in[1]` feeds `sound_in` and `led` can drive `uo_out`, so a board can decode a tone played by a second board.

## Interface
- `COUNT_W`, default 10: width of the edge counter. The counter saturates at 2^COUNT_W-1.
- `SYNC_STAGES`, default 2: number of input synchroniser flops. The minimum is 2.
- `clk` in, 1 bit: the single clock.
- `rst` in, 1 bit: reset. Synchronous, active-high.
- `ticks_per_milli` in, 16 bits: number of clk cycles per millisecond. The top level ties it to 100.
- `sound_in` in, 1 bit: asynchronous square-wave tone input.
- `led` out, 8 bits: 7-segment pattern. bit0=a … bit6=g, bit7=dp, all active-high.
- `note` out, 4 bits: 0 = silence, 1..8 = C4,D4,E4,F4,G4,A4,B4,C5, 15 = out of range.
- `edge_count` out, COUNT_W bits: rising-edge count latched from the last completed window.
- `valid` out, 1 bit: one-cycle pulse when `note`, `led` and `edge_count` update.

## Operation
**Input path**
- `sound_in` passes through SYNC_STAGES flops, then one delay flop for edge detection.
- `rise` = synchronised value is 1 and delayed value is 0.

**Millisecond tick**
- `tick_cnt` increments every cycle.
- When `tick_cnt >= ticks_per_milli-1`, it clears and `ms_tick` pulses.
- `ticks_per_milli` of 0 or 1 gives `ms_tick` every cycle.
- Because the compare is `>=`, lowering `ticks_per_milli` mid-count never hangs the counter.

**Gate**
- `ms_cnt` counts `ms_tick` from 0 to 99.
- `gate_end` = `ms_tick` and `ms_cnt==99`. `ms_cnt` then wraps to 0.

**Edge counter**
- Increments on `rise` and saturates at 2^COUNT_W-1.
- On `gate_end`, the final count is latched. It includes a `rise` occurring in the same cycle.
- The counter restarts at 0 in the next cycle. An edge in the `gate_end` cycle is not carried into the next window.

**Classification** of latched count c (edges per 100 ms):
- 0 → note 0, led 0x00
- 24..27 → 1, 0x39 (C)
- 28..31 → 2, 0x5E (d)
- 32..33 → 3, 0x79 (E)
- 34..36 → 4, 0x71 (F)
- 37..41 → 5, 0x3D (G)
- 42..46 → 6, 0x77 (A)
- 47..50 → 7, 0x7C (b)
- 51..55 → 8, 0xB9 (C with dp)
- any other value, including saturation → 15, 0x40 (dash)

**Outputs**
- `note`, `led` and `edge_count` are registered. They hold their value between windows.

**Reset**
- `rst` clears the synchroniser, `tick_cnt`, `ms_cnt` and the edge counter, and discards any partial window.
- Output reset values: `led`=0x00, `note`=0, `edge_count`=0, `valid`=0.
- The first `valid` arrives 100 ms after `rst` deasserts.

## Timing
- Input-to-`rise` latency: SYNC_STAGES+1 cycles.
- Window length: exactly `100*ticks_per_milli` cycles (200 cycles at `ticks_per_milli`=2).
- The first window starts on the cycle after `rst` deasserts.
- `valid`, `note`, `led` and `edge_count` all change on the cycle after `gate_end`. `valid` is high for exactly that one cycle.
- `rst` asserted in the same cycle as `gate_end`: reset wins. No `valid` pulse, outputs cleared.
- Tones with half-period shorter than 1 cycle are not supported. Results for them are undefined but must not exceed saturation.

## Test plan
- `ticks_per_milli`=2, `sound_in` = 50% square wave with period 8 cycles, held for several windows → from the second window onward, `edge_count`=25, `note`=1, `led`=0x39, `valid` pulse every 200 cycles.
- Same settings, period 4 → `edge_count`=50, `note`=7, `led`=0x7C. Period 7 → `edge_count` 28 or 29, `note`=2, `led`=0x5E.
- `sound_in` held low → `edge_count`=0, `note`=0, `led`=0x00, `valid` still pulses every 200 cycles.
- `ticks_per_milli`=2, period 2 → `edge_count`=100, `note`=15, `led`=0x40. Then `ticks_per_milli`=100, COUNT_W=10, period 2 → `edge_count`=1023 (saturated), `note`=15.
- Period-8 tone with `rst` pulsed at cycle 150 of a window → all outputs 0 the next cycle. The following `valid` comes 200 cycles after `rst` falls, with `edge_count`=25.
- `ticks_per_milli` changed from 100 to 2 mid-window → no lockup. Subsequent windows are 200 cycles, and classification is correct from the first full window after the change.

Source files
------------

// File: rtl/tone_decoder_if.sv
// rtl/tone_decoder_if.sv - tone input and note display signal bundle for tone_decoder
interface tone_decoder_if #(
  parameter int COUNT_W = 10
);
  logic [15:0]        ticks_per_milli;
  logic               sound_in;
  logic [7:0]         led;
  logic [3:0]         note;
  logic [COUNT_W-1:0] edge_count;
  logic               valid;

  modport master (
    output ticks_per_milli, sound_in,
    input  led, note, edge_count, valid
  );

  modport slave (
    input  ticks_per_milli, sound_in,
    output led, note, edge_count, valid
  );
endinterface

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - counts square-wave rising edges per 100 ms gate and classifies the note
module tone_decoder #(
  parameter int COUNT_W     = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  tone_decoder_if.slave bus
);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   del_q;
  logic                   rise;
  logic [15:0]            tick_cnt;
  logic                   ms_tick;
  logic [6:0]             ms_cnt;
  logic                   gate_end;
  logic [COUNT_W-1:0]     edge_cnt;
  logic [COUNT_W-1:0]     final_cnt;
  logic [3:0]             cls_note;
  logic [7:0]             cls_led;

  // Synchronise the asynchronous tone, then keep one extra flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      del_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sound_in};
      del_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~del_q;

  // The >= compare lets a lowered ticks_per_milli clear the counter instead of overshooting forever
  assign ms_tick  = (bus.ticks_per_milli <= 16'd1) || (tick_cnt >= bus.ticks_per_milli - 16'd1);
  assign gate_end = ms_tick && (ms_cnt == 7'd99);

  // Millisecond prescaler
  always_ff @(posedge clk) begin
    if (rst || ms_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // 100 ms gate: counts milliseconds 0..99 and wraps at gate_end
  always_ff @(posedge clk) begin
    if (rst || gate_end) begin
      ms_cnt <= '0;
    end else if (ms_tick) begin
      ms_cnt <= ms_cnt + 7'd1;
    end
  end

  // Count including a rise in the current cycle, so the gate_end cycle's edge lands in the latched value
  assign final_cnt = (rise && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_ONE : edge_cnt;

  // Saturating edge counter; restarts from zero after each gate so no edge carries over
  always_ff @(posedge clk) begin
    if (rst || gate_end) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= final_cnt;
    end
  end

  // Map the window's edge count onto a note number and its 7-segment letter
  always_comb begin
    logic [31:0] c;
    c        = 32'(final_cnt);
    cls_note = 4'd15;
    cls_led  = 8'h40;
    if (final_cnt == CNT_MAX) begin
      cls_note = 4'd15;
      cls_led  = 8'h40;
    end else if (c == 32'd0) begin
      cls_note = 4'd0;
      cls_led  = 8'h00;
    end else if (c >= 32'd24 && c <= 32'd27) begin
      cls_note = 4'd1;
      cls_led  = 8'h39;
    end else if (c >= 32'd28 && c <= 32'd31) begin
      cls_note = 4'd2;
      cls_led  = 8'h5E;
    end else if (c >= 32'd32 && c <= 32'd33) begin
      cls_note = 4'd3;
      cls_led  = 8'h79;
    end else if (c >= 32'd34 && c <= 32'd36) begin
      cls_note = 4'd4;
      cls_led  = 8'h71;
    end else if (c >= 32'd37 && c <= 32'd41) begin
      cls_note = 4'd5;
      cls_led  = 8'h3D;
    end else if (c >= 32'd42 && c <= 32'd46) begin
      cls_note = 4'd6;
      cls_led  = 8'h77;
    end else if (c >= 32'd47 && c <= 32'd50) begin
      cls_note = 4'd7;
      cls_led  = 8'h7C;
    end else if (c >= 32'd51 && c <= 32'd55) begin
      cls_note = 4'd8;
      cls_led  = 8'hB9;
    end
  end

  // Registered results: update once per gate, hold between gates; reset beats a coincident gate_end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.led        <= 8'h00;
      bus.note       <= 4'd0;
      bus.edge_count <= '0;
      bus.valid      <= 1'b0;
    end else begin
      bus.valid <= gate_end;
      if (gate_end) begin
        bus.led        <= cls_led;
        bus.note       <= cls_note;
        bus.edge_count <= final_cnt;
      end
    end
  end
endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - self-checking bench for tone_decoder against a window-level reference model
module tb_tone_decoder;
  localparam int COUNT_W     = 10;
  localparam int SYNC_STAGES = 2;
  localparam int MAXC        = (1 << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_v = 0;

  tone_decoder_if #(.COUNT_W(COUNT_W)) tif ();

  tone_decoder #(.COUNT_W(COUNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  always #5 clk = ~clk;

  // cycle counter, one per rising clock edge
  always @(posedge clk) cyc <= cyc + 1;

  // tone generator: 0 = held low, 1 = periodic hi_len/lo_len, 2 = random run lengths
  int mode = 0;
  int hi_len = 4;
  int lo_len = 4;
  int run_left = 0;
  always @(negedge clk) begin
    if (mode == 0) begin
      tif.sound_in = 1'b0;
      run_left = 0;
    end else if (run_left <= 1) begin
      tif.sound_in = ~tif.sound_in;
      if (mode == 1) run_left = tif.sound_in ? hi_len : lo_len;
      else run_left = int'($urandom_range(1, 6));
    end else begin
      run_left = run_left - 1;
    end
  end

  // reference model: the tone as seen SYNC_STAGES edges late, windows of 100*ticks_per_milli edges
  logic hist [0:SYNC_STAGES];
  int   pos = 0;
  int   cnt = 0;
  int   exp_q[$];
  bit   resync = 1'b0;
  always @(posedge clk) begin : model
    bit rise_m;
    int win_len;
    rise_m  = (hist[SYNC_STAGES-1] === 1'b1) && (hist[SYNC_STAGES] === 1'b0);
    win_len = 100 * ((tif.ticks_per_milli < 16'd2) ? 1 : int'(tif.ticks_per_milli));
    if (rst) begin
      pos = 0;
      cnt = 0;
      resync = 1'b0;
      exp_q.delete();
      for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 1'b0;
    end else begin
      if (resync && tif.valid === 1'b1) begin
        pos = 0;
        cnt = 0;
        resync = 1'b0;
      end
      pos = pos + 1;
      if (rise_m && cnt < MAXC) cnt = cnt + 1;
      if (pos >= win_len) begin
        if (!resync) exp_q.push_back(cnt);
        pos = 0;
        cnt = 0;
      end
      for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = tif.sound_in;
    end
  end

  function automatic logic [31:0] ref_note(input int c);
    int lo [8] = '{24, 28, 32, 34, 37, 42, 47, 51};
    int hi [8] = '{27, 31, 33, 36, 41, 46, 50, 55};
    if (c >= MAXC) return 32'd15;
    if (c == 0) return 32'd0;
    for (int i = 0; i < 8; i++) if (c >= lo[i] && c <= hi[i]) return 32'(i + 1);
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_led(input int c);
    logic [7:0] tab [9] = '{8'h00, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h77, 8'h7C, 8'hB9};
    logic [31:0] n;
    n = ref_note(c);
    if (n == 32'd15) return 32'h40;
    return 32'(tab[n]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // wait for the next valid pulse, check its spacing, its contents against the model and its width
  task automatic wait_window(input int budget, input int want_gap, input bit cmp);
    int n;
    int e;
    n = 0;
    while (tif.valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 32'(tif.valid), 32'd1);
    if (tif.valid === 1'b1) begin
      if (want_gap > 0) chk("valid_gap", 32'(cyc - last_v), 32'(want_gap));
      last_v = cyc;
      if (cmp) begin
        chk("model_window_ready", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("edge_count", 32'(tif.edge_count), 32'(e));
          chk("note", 32'(tif.note), ref_note(e));
          chk("led", 32'(tif.led), ref_led(e));
        end
      end
      @(negedge clk);
      chk("valid_one_cycle", 32'(tif.valid), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tif.sound_in = 1'b0;
    tif.ticks_per_milli = 16'd2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(tif.led), 32'h00);
    chk("rst_note", 32'(tif.note), 32'd0);
    chk("rst_edge_count", 32'(tif.edge_count), 32'd0);
    chk("rst_valid", 32'(tif.valid), 32'd0);
    rst = 1'b0;
    last_v = cyc;

    // period 8 -> C4
    hi_len = 4; lo_len = 4; mode = 1;
    repeat (3) wait_window(300, 200, 1'b1);
    chk("p8_count", 32'(tif.edge_count), 32'd25);
    chk("p8_note", 32'(tif.note), 32'd1);
    chk("p8_led", 32'(tif.led), 32'h39);

    // period 4 -> B4
    hi_len = 2; lo_len = 2;
    repeat (3) wait_window(300, 200, 1'b1);
    chk("p4_count", 32'(tif.edge_count), 32'd50);
    chk("p4_note", 32'(tif.note), 32'd7);
    chk("p4_led", 32'(tif.led), 32'h7C);

    // period 7 -> D4
    hi_len = 3; lo_len = 4;
    repeat (3) wait_window(300, 200, 1'b1);
    chk("p7_count_range", 32'(tif.edge_count == 28 || tif.edge_count == 29), 32'd1);
    chk("p7_note", 32'(tif.note), 32'd2);
    chk("p7_led", 32'(tif.led), 32'h5E);

    // silence still produces a result every window
    mode = 0;
    repeat (3) wait_window(300, 200, 1'b1);
    chk("low_count", 32'(tif.edge_count), 32'd0);
    chk("low_note", 32'(tif.note), 32'd0);
    chk("low_led", 32'(tif.led), 32'h00);

    // period 2 -> 100 edges, out of range
    hi_len = 1; lo_len = 1; mode = 1;
    repeat (3) wait_window(300, 200, 1'b1);
    chk("p2_count", 32'(tif.edge_count), 32'd100);
    chk("p2_note", 32'(tif.note), 32'd15);
    chk("p2_led", 32'(tif.led), 32'h40);

    // random periodic tones, then random run lengths
    for (int k = 0; k < 3; k++) begin
      hi_len = int'($urandom_range(1, 8));
      lo_len = int'($urandom_range(1, 8));
      repeat (2) wait_window(300, 200, 1'b1);
    end
    mode = 2;
    repeat (3) wait_window(300, 200, 1'b1);

    // reset 150 cycles into a window of a period-8 tone
    hi_len = 4; lo_len = 4; mode = 1;
    wait_window(300, 200, 1'b1);
    n = 0;
    while (pos != 150 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_cycle_150", 32'(pos), 32'd150);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_led", 32'(tif.led), 32'h00);
    chk("midrst_note", 32'(tif.note), 32'd0);
    chk("midrst_edge_count", 32'(tif.edge_count), 32'd0);
    chk("midrst_valid", 32'(tif.valid), 32'd0);
    rst = 1'b0;
    last_v = cyc;
    wait_window(300, 200, 1'b1);
    chk("after_rst_note", 32'(tif.note), 32'd1);
    chk("after_rst_led", 32'(tif.led), 32'h39);

    // 1 ms = 100 cycles, period 2: 5000 edges saturate the counter
    rst = 1'b1;
    tif.ticks_per_milli = 16'd100;
    hi_len = 1; lo_len = 1;
    @(negedge clk);
    rst = 1'b0;
    last_v = cyc;
    wait_window(10100, 10000, 1'b1);
    chk("sat_count", 32'(tif.edge_count), 32'(MAXC));
    chk("sat_note", 32'(tif.note), 32'd15);
    chk("sat_led", 32'(tif.led), 32'h40);

    // lower ticks_per_milli part way through a window; the gate must recover
    hi_len = 4; lo_len = 4;
    repeat (3000) @(negedge clk);
    tif.ticks_per_milli = 16'd2;
    resync = 1'b1;
    wait_window(20000, 0, 1'b0);
    wait_window(300, 200, 1'b1);
    chk("retick_count", 32'(tif.edge_count), 32'd25);
    chk("retick_note", 32'(tif.note), 32'd1);
    chk("retick_led", 32'(tif.led), 32'h39);
    wait_window(300, 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
